// File: rtl/logIP_pkg.sv
// Shared logIP types and constants: SUMP/OLS opcodes, flow-control state,
// responder FSM/response kinds, and the ID/metadata byte constants.
package logIP_pkg;

   typedef enum logic [7:0] {
      CMD_S_SOFT_RESET         = 8'h00,
      CMD_S_RUN                = 8'h01,
      CMD_S_ID                 = 8'h02,
      CMD_OLS_QUERY_META_DATA  = 8'h04,
      CMD_OLS_FINISH_NOW       = 8'h05,
      CMD_OLS_QUERY_INPUT_DATA = 8'h06,
      CMD_S_XON                = 8'h11,
      CMD_S_XOFF               = 8'h13
   } opcode_t;

   typedef enum logic {XON = 1'b0, XOFF = 1'b1} xcrtl_t;

   typedef enum logic [1:0] {RSP_ID, RSP_META, RSP_INPUT} rsp_kind_t;

   typedef enum logic {IDLE, SEND} rsp_state_t;

   localparam logic [7:0] ID_BYTE0 = 8'h31;
   localparam logic [7:0] ID_BYTE1 = 8'h41;
   localparam logic [7:0] ID_BYTE2 = 8'h4C;
   localparam logic [7:0] ID_BYTE3 = 8'h53;

   localparam logic [7:0] META_END        = 8'h00;
   localparam logic [7:0] META_DEV_NAME   = 8'h01;
   localparam logic [7:0] META_FW_VER     = 8'h02;
   localparam logic [7:0] META_MEM_BYTES  = 8'h21;
   localparam logic [7:0] META_MAX_RATE   = 8'h23;
   localparam logic [7:0] META_NUM_PROBES = 8'h40;
   localparam logic [7:0] META_PROTO_VER  = 8'h41;

   localparam logic [7:0] PROTOCOL_VERSION = 8'd2;

   function automatic logic is_query(opcode_t op);
      return (op == CMD_S_ID) || (op == CMD_OLS_QUERY_META_DATA) ||
             (op == CMD_OLS_QUERY_INPUT_DATA);
   endfunction

   function automatic rsp_kind_t kind_of(opcode_t op);
      case (op)
         CMD_OLS_QUERY_META_DATA:  return RSP_META;
         CMD_OLS_QUERY_INPUT_DATA: return RSP_INPUT;
         default:                  return RSP_ID;
      endcase
   endfunction

   function automatic logic [4:0] last_idx(rsp_kind_t k);
      return (k == RSP_META) ? 5'd31 : 5'd3;
   endfunction

endpackage

// File: rtl/sump_meta_rom.sv
// Combinational metadata ROM: 5-bit byte index to OLS metadata record byte.
module sump_meta_rom
   import logIP_pkg::*;
#(
   parameter int unsigned MEM_BYTES   = 24576,
   parameter int unsigned MAX_RATE_HZ = 200000000,
   parameter int unsigned NUM_PROBES  = 32
) (
   input  logic [4:0] idx,
   output logic [7:0] data
);

   localparam logic [31:0] MEM_W  = MEM_BYTES;
   localparam logic [31:0] RATE_W = MAX_RATE_HZ;
   localparam logic [7:0]  PROBES = 8'(NUM_PROBES);

   always_comb begin
      data = META_END;
      case (idx)
         5'd0:    data = META_DEV_NAME;
         5'd1:    data = 8'h4C;  // "LogIP v0.1"
         5'd2:    data = 8'h6F;
         5'd3:    data = 8'h67;
         5'd4:    data = 8'h49;
         5'd5:    data = 8'h50;
         5'd6:    data = 8'h20;
         5'd7:    data = 8'h76;
         5'd8:    data = 8'h30;
         5'd9:    data = 8'h2E;
         5'd10:   data = 8'h31;
         5'd11:   data = 8'h00;
         5'd12:   data = META_FW_VER;
         5'd13:   data = 8'h30;  // "0.1"
         5'd14:   data = 8'h2E;
         5'd15:   data = 8'h31;
         5'd16:   data = 8'h00;
         5'd17:   data = META_MEM_BYTES;
         5'd18:   data = MEM_W[31:24];
         5'd19:   data = MEM_W[23:16];
         5'd20:   data = MEM_W[15:8];
         5'd21:   data = MEM_W[7:0];
         5'd22:   data = META_MAX_RATE;
         5'd23:   data = RATE_W[31:24];
         5'd24:   data = RATE_W[23:16];
         5'd25:   data = RATE_W[15:8];
         5'd26:   data = RATE_W[7:0];
         5'd27:   data = META_NUM_PROBES;
         5'd28:   data = PROBES;
         5'd29:   data = META_PROTO_VER;
         5'd30:   data = PROTOCOL_VERSION;
         default: data = META_END;
      endcase
   end

endmodule

// File: rtl/sump_responder.sv
// SUMP/OLS query responder: serialises ID, metadata or an input snapshot
// to the UART TX over valid/ready, honouring XON/XOFF.
module sump_responder
   import logIP_pkg::*;
#(
   parameter int unsigned MEM_BYTES   = 24576,
   parameter int unsigned MAX_RATE_HZ = 200000000,
   parameter int unsigned NUM_PROBES  = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  opcode_t     cmd_i,
   input  logic        cmd_stb_i,
   input  xcrtl_t      xctrl_i,
   input  logic [31:0] smpl_i,
   output logic [7:0]  tx_data_o,
   output logic        tx_vld_o,
   input  logic        tx_rdy_i,
   output logic        busy_o
);

   rsp_state_t  state_q, state_d;
   rsp_kind_t   kind_q, kind_d, ld_kind;
   logic [4:0]  idx_q, idx_d, ld_idx;
   logic [31:0] smpl_q, smpl_d, ld_smpl;
   logic [7:0]  rom_byte, data_d;
   logic        vld_d, load;
   logic        soft_rst, accept, xfer, last_xfer, xon;

   assign soft_rst  = cmd_stb_i && (cmd_i == CMD_S_SOFT_RESET);
   assign accept    = (state_q == IDLE) && cmd_stb_i && is_query(cmd_i);
   assign xfer      = tx_vld_o && tx_rdy_i;
   assign last_xfer = (state_q == SEND) && xfer && (idx_q == last_idx(kind_q));
   assign xon       = (xctrl_i == XON);
   assign busy_o    = (state_q == SEND);

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)    state_d = SEND;
         SEND:    if (last_xfer) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (soft_rst) state_d = IDLE;
   end

   // The byte to present next is chosen from the index/kind/sample it will
   // belong to, so byte 0 can be registered in the accept cycle itself.
   always_comb begin
      idx_d   = idx_q;
      kind_d  = kind_q;
      smpl_d  = smpl_q;
      ld_idx  = idx_q;
      ld_kind = kind_q;
      ld_smpl = smpl_q;
      load    = 1'b0;
      if (soft_rst) begin
         idx_d = '0;
      end else if (accept) begin
         kind_d  = kind_of(cmd_i);
         smpl_d  = smpl_i;
         idx_d   = '0;
         ld_kind = kind_d;
         ld_smpl = smpl_i;
         ld_idx  = '0;
         load    = xon;
      end else if (state_q == SEND) begin
         if (xfer) begin
            idx_d  = last_xfer ? '0 : idx_q + 5'd1;
            ld_idx = idx_q + 5'd1;
            load   = xon && !last_xfer;
         end else if (!tx_vld_o) begin
            load = xon;
         end
      end
   end

   sump_meta_rom #(
      .MEM_BYTES   (MEM_BYTES),
      .MAX_RATE_HZ (MAX_RATE_HZ),
      .NUM_PROBES  (NUM_PROBES)
   ) u_meta_rom (
      .idx  (ld_idx),
      .data (rom_byte)
   );

   always_comb begin
      vld_d  = tx_vld_o && !xfer && !soft_rst;
      data_d = tx_data_o;
      if (load) begin
         vld_d = 1'b1;
         case (ld_kind)
            RSP_META:  data_d = rom_byte;
            RSP_INPUT: data_d = ld_smpl[8*ld_idx[1:0] +: 8];
            default: begin
               case (ld_idx[1:0])
                  2'd0:    data_d = ID_BYTE0;
                  2'd1:    data_d = ID_BYTE1;
                  2'd2:    data_d = ID_BYTE2;
                  default: data_d = ID_BYTE3;
               endcase
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tx_data_o <= '0;
         tx_vld_o  <= 1'b0;
         idx_q     <= '0;
         kind_q    <= RSP_ID;
         smpl_q    <= '0;
      end else begin
         tx_data_o <= data_d;
         tx_vld_o  <= vld_d;
         idx_q     <= idx_d;
         kind_q    <= kind_d;
         smpl_q    <= smpl_d;
      end
   end

endmodule

// File: tb/tb_sump_responder.sv
// Directed self-checking bench for sump_responder; inputs driven and outputs
// observed on the falling edge.
module tb_sump_responder;
   import logIP_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   opcode_t     cmd = CMD_S_RUN;
   logic        cmd_stb = 1'b0;
   xcrtl_t      xctrl = XON;
   logic [31:0] smpl = '0;
   logic [7:0]  tx_data;
   logic        tx_vld;
   logic        tx_rdy = 1'b1;
   logic        busy;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   logic [7:0] exp_b [32];
   logic [7:0] meta_exp [32] = '{
      8'h01, 8'h4C, 8'h6F, 8'h67, 8'h49, 8'h50, 8'h20, 8'h76,
      8'h30, 8'h2E, 8'h31, 8'h00, 8'h02, 8'h30, 8'h2E, 8'h31,
      8'h00, 8'h21, 8'h00, 8'h00, 8'h60, 8'h00, 8'h23, 8'h0B,
      8'hEB, 8'hC2, 8'h00, 8'h40, 8'h20, 8'h41, 8'h02, 8'h00};

   sump_responder #(
      .MEM_BYTES   (24576),
      .MAX_RATE_HZ (200000000),
      .NUM_PROBES  (32)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .cmd_i     (cmd),
      .cmd_stb_i (cmd_stb),
      .xctrl_i   (xctrl),
      .smpl_i    (smpl),
      .tx_data_o (tx_data),
      .tx_vld_o  (tx_vld),
      .tx_rdy_i  (tx_rdy),
      .busy_o    (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic issue(input opcode_t op);
      cmd     = op;
      cmd_stb = 1'b1;
      @(negedge clk);
      cmd_stb = 1'b0;
   endtask

   task automatic load_id();
      for (int i = 0; i < 32; i++) exp_b[i] = 8'h00;
      exp_b[0] = 8'h31; exp_b[1] = 8'h41; exp_b[2] = 8'h4C; exp_b[3] = 8'h53;
   endtask

   // Expects exp_b[first..n-1] on consecutive cycles with tx_rdy high,
   // optionally strobing op on cycles flagged in mask, then an idle block.
   task automatic expect_stream(input string tag, input int first, input int n,
                                input logic [31:0] mask, input opcode_t op);
      for (int i = first; i < n; i++) begin
         check($sformatf("%s vld%0d", tag, i), {31'd0, tx_vld}, 32'd1);
         check($sformatf("%s byte%0d", tag, i), {24'd0, tx_data}, {24'd0, exp_b[i]});
         if (i == first) check($sformatf("%s busy", tag), {31'd0, busy}, 32'd1);
         cmd     = op;
         cmd_stb = mask[i];
         @(negedge clk);
         cmd_stb = 1'b0;
      end
      check($sformatf("%s end_vld", tag), {31'd0, tx_vld}, 32'd0);
      check($sformatf("%s end_busy", tag), {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst data", {24'd0, tx_data}, 32'h00);
      check("rst vld", {31'd0, tx_vld}, 32'd0);
      check("rst busy", {31'd0, busy}, 32'd0);
      @(negedge clk);

      // ID query
      load_id();
      issue(CMD_S_ID);
      expect_stream("id", 0, 4, 32'd0, CMD_S_RUN);

      // Input snapshot, sample changes after the accept edge
      smpl = 32'hDEADBEEF;
      issue(CMD_OLS_QUERY_INPUT_DATA);
      smpl = 32'h12345678;
      exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
      expect_stream("inp", 0, 4, 32'd0, CMD_S_RUN);

      // Metadata
      exp_b = meta_exp;
      issue(CMD_OLS_QUERY_META_DATA);
      expect_stream("meta", 0, 32, 32'd0, CMD_S_RUN);

      // Flow control with backpressure on byte 2
      issue(CMD_OLS_QUERY_META_DATA);
      check("fc b0", {24'd0, tx_data}, 32'h01);
      @(negedge clk);
      check("fc b1", {24'd0, tx_data}, 32'h4C);
      @(negedge clk);
      tx_rdy = 1'b0;
      xctrl  = XOFF;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("fc hold_vld%0d", k), {31'd0, tx_vld}, 32'd1);
         check($sformatf("fc hold_data%0d", k), {24'd0, tx_data}, 32'h6F);
         @(negedge clk);
      end
      tx_rdy = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("fc xoff_vld%0d", k), {31'd0, tx_vld}, 32'd0);
         check($sformatf("fc xoff_busy%0d", k), {31'd0, busy}, 32'd1);
         @(negedge clk);
      end
      check("fc xon_edge_vld", {31'd0, tx_vld}, 32'd0);
      xctrl = XON;
      @(negedge clk);
      expect_stream("fc", 3, 32, 32'd0, CMD_S_RUN);

      // Soft reset coinciding with metadata byte 10, then a clean ID query
      exp_b = meta_exp;
      issue(CMD_OLS_QUERY_META_DATA);
      expect_stream("srst", 0, 11, 32'h0000_0400, CMD_S_SOFT_RESET);
      load_id();
      issue(CMD_S_ID);
      expect_stream("post_srst", 0, 4, 32'd0, CMD_S_RUN);

      // Strobes while busy (including the final-transfer cycle) are dropped
      issue(CMD_S_ID);
      expect_stream("drop", 0, 4, 32'h0000_000A, CMD_S_ID);
      @(negedge clk);
      check("drop idle_vld", {31'd0, tx_vld}, 32'd0);
      check("drop idle_busy", {31'd0, busy}, 32'd0);

      // Non-query opcode while idle is ignored
      issue(CMD_S_RUN);
      check("run vld", {31'd0, tx_vld}, 32'd0);
      check("run busy", {31'd0, busy}, 32'd0);
      @(negedge clk);

      // rst_i mid-response
      issue(CMD_S_ID);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid data", {24'd0, tx_data}, 32'h00);
      check("rst_mid vld", {31'd0, tx_vld}, 32'd0);
      check("rst_mid busy", {31'd0, busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sump_responder.md
# sump_responder

Transmit-side responder for the SUMP/OLS command set. It takes decoded query opcodes from the command receiver and serialises the ID string, the metadata record, or a 32-bit input snapshot as a byte stream. The stream goes to the UART transmitter over a valid/ready handshake and honours the current XON/XOFF state. It sits between the command decoder and the UART TX in the logIP top level.

## Interface
- `MEM_BYTES`, default 24576: sample memory size reported under metadata token 0x21.
- `MAX_RATE_HZ`, default 200000000: maximum sample rate reported under token 0x23.
- `NUM_PROBES`, default 32: probe count reported under token 0x40, 8-bit value.
- `clk_i`, input, 1: system clock.
- `rst_i`, input, 1: reset. Synchronous, active-high.
- `cmd_i`, input, 8 (`opcode_t`): decoded opcode.
- `cmd_stb_i`, input, 1: one-cycle strobe qualifying `cmd_i`.
- `xctrl_i`, input, 1 (`xcrtl_t`): current flow-control state, `XON` or `XOFF`.
- `smpl_i`, input, 32: latest sample from the sampler.
- `tx_data_o`, output, 8: byte to transmit.
- `tx_vld_o`, output, 1: `tx_data_o` is valid.
- `tx_rdy_i`, input, 1: UART TX accepts the byte.
- `busy_o`, output, 1: a response is in progress.

## Operation
- **States:** `IDLE`, `SEND`.
- **Command acceptance:** in `IDLE`, `cmd_stb_i` high with a query opcode selects a response, clears byte index `idx` (5 bits) and moves to `SEND`.
- **`CMD_S_ID`:** 4 bytes, in order 0x31, 0x41, 0x4C, 0x53 ("1ALS").
- **`CMD_OLS_QUERY_INPUT_DATA`:** `smpl_i` is latched in the accept cycle. 4 bytes are sent, LSB first.
- **`CMD_OLS_QUERY_META_DATA`:** 32 bytes, in this order:
  - 0x01, "LogIP v0.1", 0x00
  - 0x02, "0.1", 0x00
  - 0x21, `MEM_BYTES` as 4 bytes MSB first
  - 0x23, `MAX_RATE_HZ` as 4 bytes MSB first
  - 0x40, `NUM_PROBES[7:0]`
  - 0x41, 0x02
  - 0x00
- **Other opcodes:**
  - All opcodes other than the three queries and `CMD_S_SOFT_RESET` are ignored in every state.
  - Strobes arriving in `SEND` are dropped, with no queuing.
- **`CMD_S_SOFT_RESET` strobe:** forces `IDLE` next cycle from any state, even mid-handshake. `tx_vld_o` drops and `idx` clears.
- **Handshake in `SEND`:**
  - A byte transfers on a cycle where `tx_vld_o` and `tx_rdy_i` are both high.
  - On transfer, `idx` increments. On the last byte, the block returns to `IDLE`.
- **Flow control:**
  - `tx_vld_o` rises only while `xctrl_i == XON`.
  - Once raised, `tx_vld_o` and `tx_data_o` stay stable until the transfer completes, even if XOFF arrives. The only exceptions are soft reset and `rst_i`.
  - Under XOFF, no further byte is presented.
- **`tx_data_o` source:**
  - Registered.
  - ID and metadata bytes come from a ROM indexed by `idx`.
  - Snapshot bytes come from the latched sample.

## Timing
- **Reset values:** `tx_data_o` = 0x00, `tx_vld_o` = 0, `busy_o` = 0, state `IDLE`, `idx` = 0, sample latch = 0.
- **Latency:** a strobe accepted at cycle N gives `busy_o` = 1 and, under XON, `tx_vld_o` = 1 with byte 0 at N+1.
- **Back-to-back bytes:**
  - With `tx_rdy_i` tied high and XON, one byte transfers per cycle.
  - A 4-byte response therefore occupies cycles N+1..N+4, and `busy_o` = 0 at N+5.
  - After the final transfer, `tx_vld_o` = 0 the next cycle.
- **Next command:** earliest acceptance is the first cycle with `busy_o` = 0.
- **Simultaneous events:**
  - Strobe in the same cycle as the final transfer: the command is dropped.
  - Soft reset coinciding with a transfer: the reset wins and the byte counts as sent.
- **XOFF while idle in `SEND`:** `tx_vld_o` stays 0 until XON. Resumption is the cycle after `xctrl_i` returns to XON.
- **`rst_i` mid-response:** all outputs take their reset values on the next edge.

## Structure
- **Shared package `logIP_pkg`:**
  - Add the ID byte constants.
  - Add the metadata token constants (0x00, 0x01, 0x02, 0x21, 0x23, 0x40, 0x41).
  - Add the protocol version constant 2.
  - Add the response-kind enum (`RSP_ID`, `RSP_META`, `RSP_INPUT`).
  - Add the state enum.
- **Sub-module `sump_meta_rom`:** combinational, mapping a 5-bit index plus the three parameters to a metadata byte.

## Test plan
- **ID query:** `CMD_S_ID` strobe with `tx_rdy_i` = 1 and XON -> bytes 0x31, 0x41, 0x4C, 0x53 on 4 consecutive cycles starting one cycle after the strobe. `busy_o` falls after the fourth.
- **Input snapshot:** `smpl_i` = 0xDEADBEEF at accept, then changed -> 0xEF, 0xBE, 0xAD, 0xDE.
- **Metadata:** `CMD_OLS_QUERY_META_DATA` -> exactly 32 bytes. Bytes 17..21 = 0x21, 0x00, 0x00, 0x60, 0x00. Bytes 22..26 = 0x23, 0x0B, 0xEB, 0xC2, 0x00. Last byte 0x00.
- **Flow control and backpressure:** XOFF asserted after byte 1 while byte 2 is already valid with `tx_rdy_i` = 0 -> byte 2 is held stable until `tx_rdy_i`, then no valid until XON. The remaining bytes arrive in order without loss or duplication.
- **Soft reset mid-stream:** `CMD_S_SOFT_RESET` during metadata byte 10 -> `tx_vld_o` = 0 and `busy_o` = 0 next cycle. A subsequent ID query starts cleanly at 0x31.
- **Dropped and ignored commands:** `CMD_S_ID` strobed while busy, and `CMD_S_RUN` strobed while idle -> no extra bytes and no state change.
